fwrisc_prog_loader: RTL and testbench
=====================================

# fwrisc_prog_loader

Parametrised program loader that turns a received UART byte stream into word writes into the fwrisc instruction/data memory. It replaces the fixed byte-at-a-time load path with a framed protocol: sync byte, word count, payload, optional checksum. Word width, memory depth, base address and inter-byte timeout are all configurable. It sits between the UART receiver (byte + strobe) and the memory write port, and reports progress, completion, overflow and error to the core wrapper.

## Interface
Parameters:
- DATA_W, 32, memory word width in bits; multiple of 8, 8..64; BYTES = DATA_W/8
- ADDR_W, 12, memory word-address width; capacity 2**ADDR_W words
- BASE_ADDR, 0, first word address written (ADDR_W bits)
- SYNC_BYTE, 8'hA5, frame start byte
- TIMEOUT_CYC, 1000000, max sys_clk cycles between bytes inside a frame; counter width $clog2(TIMEOUT_CYC+1)

Ports:
- sys_clk  in  1  clock; the block's only clock
- sys_rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- restart  in  1  one-cycle pulse; leaves DONE/ERR, returns to IDLE
- mem_we  out  1  one-cycle word write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  DATA_W  assembled word, byte 0 in bits [7:0]
- program_receiving  out  1  one-cycle pulse per accepted byte (host flow control)
- program_done  out  1  level; frame loaded successfully
- program_ov  out  1  level; word count exceeds capacity
- program_err  out  1  level; checksum mismatch or timeout
- busy  out  1  level; frame in progress (LEN_LO..CKSUM)

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CKSUM, DONE, ERR.
- IDLE: bytes other than SYNC_BYTE ignored (no program_receiving). SYNC_BYTE -> LEN_LO, clear sum, word index, byte lane.
- LEN_LO/LEN_HI: 16-bit word count N, little-endian. Both bytes added to sum. After LEN_HI: N > 2**ADDR_W - BASE_ADDR -> ERR with program_ov=1; N == 0 -> CKSUM (or DONE if checksum compiled out); else DATA.
- DATA: bytes shifted into lane 0..BYTES-1; each byte added to sum (mod 256). On lane BYTES-1: write word at BASE_ADDR + word index, increment index. After N-th word -> CKSUM (or DONE).
- CKSUM: byte c accepted; (sum + c) mod 256 == 0 -> DONE, else ERR with program_err=1.
- DONE/ERR: sticky; all rx bytes ignored; restart -> IDLE, clearing done/ov/err.
- Timeout: in LEN_LO..CKSUM, counter reloads on every accepted byte; reaching TIMEOUT_CYC -> ERR, program_err=1. Partial words already written stay written.
- Every byte accepted in LEN_LO..CKSUM and the SYNC byte produce a program_receiving pulse.

## Timing
- Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, program_receiving=0, program_done=0, program_ov=0, program_err=0, busy=0; state IDLE.
- Byte sampled at the sys_clk edge where rx_valid=1; program_receiving high the following cycle for exactly one cycle.
- mem_we/mem_addr/mem_wdata registered: valid the cycle after the final lane byte is sampled; one cycle only.
- Status flags rise the cycle after the terminating byte (or timeout terminal count).
- Back-to-back rx_valid on consecutive cycles supported at full rate.
- restart and rx_valid same cycle: restart wins, byte dropped. restart outside DONE/ERR aborts the frame to IDLE.
- sys_rst mid-frame: immediate return to reset values; a partially assembled word is discarded, not written.

## Configuration
- PROG_LOADER_CKSUM_EN defined: CKSUM state present; checksum byte required after payload; mismatch sets program_err.
- Not defined: no CKSUM state; DONE entered the cycle after the last payload byte (or after LEN_HI for N=0); program_err only from timeout; sum logic removed.

## Test plan
- DATA_W=32, frame A5 02 00 13 00 00 00 6F 00 00 00 7C (checksum on) -> writes 0x00000013 @0, 0x0000006F @1; program_done=1; 12 program_receiving pulses.
- Same frame with last byte 7D -> both words written, program_err=1, program_done=0; restart -> all flags 0, state IDLE.
- ADDR_W=4, BASE_ADDR=0, count 0x0011 -> program_ov=1 after LEN_HI, no mem_we; later bytes ignored.
- Noise bytes 00 FF 5A before A5 -> no program_receiving, no writes; then valid frame loads normally.
- TIMEOUT_CYC=100, stop after 2 payload bytes -> program_err=1 exactly 100 cycles after last byte, no mem_we.
- sys_rst asserted after 3 of 4 lane bytes -> no write; restart-free reload after release succeeds; DATA_W=8 variant writes every byte.

Source files
------------

// File: rtl/fwrisc_prog_loader.sv
// fwrisc_prog_loader: turns a framed UART byte stream (sync, length, payload) into memory word writes.
// Define PROG_LOADER_CKSUM_EN to require a trailing checksum byte after the payload.
module fwrisc_prog_loader #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [7:0]        SYNC_BYTE   = 8'hA5,
  parameter int                TIMEOUT_CYC = 1000000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              program_receiving,
  output logic              program_done,
  output logic              program_ov,
  output logic              program_err,
  output logic              busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int LW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam longint unsigned CAP = (64'd1 << ADDR_W) - 64'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef PROG_LOADER_CKSUM_EN
    CKSUM,
`endif
    DONE,
    ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        lenLo_q, lenLo_d;
  logic [15:0]       rem_q, rem_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic              done_q, done_d, ov_q, ov_d, err_q, err_d;
  logic              we_q, we_d, recv_q, recv_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [15:0]       len;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      lenLo_q <= '0;
      rem_q   <= '0;
      lane_q  <= '0;
      waddr_q <= BASE_ADDR;
      asm_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      recv_q  <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      lenLo_q <= lenLo_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      waddr_q <= waddr_d;
      asm_q   <= asm_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      we_q    <= we_d;
      recv_q  <= recv_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef PROG_LOADER_CKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Frame parser: restart beats any byte; inside a frame each idle cycle advances the timeout.
  always_comb begin
    state_d = state_q;
    lenLo_d = lenLo_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    waddr_d = waddr_q;
    asm_d   = asm_q;
    tmo_d   = tmo_q;
    done_d  = done_q;
    ov_d    = ov_q;
    err_d   = err_q;
    we_d    = 1'b0;
    recv_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len     = {rx_data, lenLo_q};
`ifdef PROG_LOADER_CKSUM_EN
    sum_d   = sum_q;
`endif
    if (restart) begin
      state_d = IDLE;
      done_d  = 1'b0;
      ov_d    = 1'b0;
      err_d   = 1'b0;
      tmo_d   = '0;
    end else if (state_q == IDLE) begin
      if (rx_valid && rx_data == SYNC_BYTE) begin
        state_d = LEN_LO;
        recv_d  = 1'b1;
        lane_d  = '0;
        waddr_d = BASE_ADDR;
        tmo_d   = '0;
`ifdef PROG_LOADER_CKSUM_EN
        sum_d   = '0;
`endif
      end
    end else if (state_q != DONE && state_q != ERR) begin
      if (rx_valid) begin
        recv_d = 1'b1;
        tmo_d  = '0;
`ifdef PROG_LOADER_CKSUM_EN
        sum_d  = sum_q + rx_data;
`endif
        case (state_q)
          LEN_LO: begin
            lenLo_d = rx_data;
            state_d = LEN_HI;
          end
          LEN_HI: begin
            if ({48'd0, len} > CAP) begin
              state_d = ERR;
              ov_d    = 1'b1;
            end else if (len == 16'd0) begin
`ifdef PROG_LOADER_CKSUM_EN
              state_d = CKSUM;
`else
              state_d = DONE;
              done_d  = 1'b1;
`endif
            end else begin
              rem_d   = len;
              state_d = DATA;
            end
          end
          DATA: begin
            asm_d[lane_q*8 +: 8] = rx_data;
            if (lane_q == LW'(BYTES - 1)) begin
              lane_d  = '0;
              we_d    = 1'b1;
              addr_d  = waddr_q;
              wdata_d = asm_d;
              waddr_d = waddr_q + ADDR_W'(1);
              rem_d   = rem_q - 16'd1;
              if (rem_q == 16'd1) begin
`ifdef PROG_LOADER_CKSUM_EN
                state_d = CKSUM;
`else
                state_d = DONE;
                done_d  = 1'b1;
`endif
              end
            end else begin
              lane_d = lane_q + LW'(1);
            end
          end
`ifdef PROG_LOADER_CKSUM_EN
          CKSUM: begin
            if (sum_d == 8'd0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end else if (tmo_q == TO_W'(TIMEOUT_CYC - 1)) begin
        state_d = ERR;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + TO_W'(1);
      end
    end
  end

  assign mem_we            = we_q;
  assign mem_addr          = addr_q;
  assign mem_wdata         = wdata_q;
  assign program_receiving = recv_q;
  assign program_done      = done_q;
  assign program_ov        = ov_q;
  assign program_err       = err_q;
  assign busy              = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);

endmodule

// File: tb/tb_fwrisc_prog_loader.sv
// Self-checking bench for fwrisc_prog_loader: directed frames plus randomized frames scored
// against a byte-stream reference model; follows PROG_LOADER_CKSUM_EN like the design.
module tb_fwrisc_prog_loader;
  localparam int                DATA_W      = 32;
  localparam int                ADDR_W      = 4;
  localparam logic [ADDR_W-1:0] BASE_ADDR   = 4'd3;
  localparam int                TIMEOUT_CYC = 100;
  localparam int                BYTES       = DATA_W / 8;
  localparam int                CAP         = (1 << ADDR_W) - int'(BASE_ADDR);
  localparam logic [7:0]        SYNC        = 8'hA5;
`ifdef PROG_LOADER_CKSUM_EN
  localparam bit CKSUM_ON = 1'b1;
`else
  localparam bit CKSUM_ON = 1'b0;
`endif

  typedef enum int {ST_IDLE, ST_BUSY, ST_DONE, ST_OV, ST_ERR} status_t;

  logic              clk, rst, rxValid, restart;
  logic [7:0]        rxData;
  logic              memWe, progRecv, progDone, progOv, progErr, busy;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;

  int checks = 0;
  int errors = 0;

  logic [7:0]        frameQ[$];
  int                expAddr[$];
  logic [DATA_W-1:0] expData[$];
  int                expRecv;
  status_t           expStatus;
  int                obsAddr[$];
  logic [DATA_W-1:0] obsData[$];
  int                obsRecv;

  logic [7:0] specFrame[12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};

  fwrisc_prog_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR),
    .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .rx_data(rxData), .rx_valid(rxValid), .restart(restart),
    .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .program_receiving(progRecv), .program_done(progDone), .program_ov(progOv),
    .program_err(progErr), .busy(busy)
  );

  // Free-running clock; inputs change on the falling edge.
  always #5 clk = ~clk;

  // Record every write strobe and receive pulse seen on the outputs.
  always @(posedge clk) begin
    if (!rst) begin
      if (memWe) begin
        obsAddr.push_back(int'(memAddr));
        obsData.push_back(memWdata);
      end
      if (progRecv) obsRecv++;
    end
  end

  task automatic clearObs();
    obsAddr.delete();
    obsData.delete();
    obsRecv = 0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    rxData  = b;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendFrame(input int gapMax);
    foreach (frameQ[i]) sendByte(frameQ[i], $urandom_range(0, gapMax));
  endtask

  task automatic pulseRestart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  // Builds noise, a frame of n random words (checksum optionally corrupted) and trailing junk.
  task automatic buildFrame(input int n, input bit badCk, input int noise, input int trailing);
    logic [7:0] b;
    logic [7:0] ck;
    frameQ.delete();
    for (int i = 0; i < noise; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h5A;
      frameQ.push_back(b);
    end
    frameQ.push_back(SYNC);
    frameQ.push_back(8'(n));
    frameQ.push_back(8'(n >> 8));
    ck = 8'(n) + 8'(n >> 8);
    for (int i = 0; i < n * BYTES; i++) begin
      b = 8'($urandom_range(0, 255));
      ck = ck + b;
      frameQ.push_back(b);
    end
    if (CKSUM_ON) frameQ.push_back(8'(0) - ck + (badCk ? 8'd1 : 8'd0));
    for (int i = 0; i < trailing; i++) frameQ.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference model: reads frameQ as a byte stream and derives writes, pulses and final status.
  task automatic runModel();
    int i;
    int n;
    int sum;
    logic [DATA_W-1:0] w;
    expAddr.delete();
    expData.delete();
    expRecv   = 0;
    expStatus = ST_IDLE;
    i = 0;
    while (i < frameQ.size() && frameQ[i] != SYNC) i++;
    if (i >= frameQ.size()) return;
    n   = int'(frameQ[i+1]) + 256 * int'(frameQ[i+2]);
    sum = int'(frameQ[i+1]) + int'(frameQ[i+2]);
    expRecv = 3;
    i += 3;
    if (n > CAP) begin
      expStatus = ST_OV;
      return;
    end
    for (int wi = 0; wi < n; wi++) begin
      w = '0;
      for (int k = 0; k < BYTES; k++) begin
        w = w | (DATA_W'(frameQ[i]) << (8 * k));
        sum += int'(frameQ[i]);
        i++;
      end
      expAddr.push_back(int'(BASE_ADDR) + wi);
      expData.push_back(w);
      expRecv += BYTES;
    end
`ifdef PROG_LOADER_CKSUM_EN
    expRecv++;
    expStatus = ((sum + int'(frameQ[i])) % 256 == 0) ? ST_DONE : ST_ERR;
`else
    expStatus = ST_DONE;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (memWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %0b exp 0", memWe); end
    checks++; if (memAddr !== BASE_ADDR) begin errors++; $display("[TB] FAIL reset_addr got %0h exp %0h", memAddr, BASE_ADDR); end
    checks++; if (memWdata !== '0) begin errors++; $display("[TB] FAIL reset_wdata got %0h exp 0", memWdata); end
    checks++; if (progRecv !== 1'b0) begin errors++; $display("[TB] FAIL reset_recv got %0b exp 0", progRecv); end
    checks++; if ({progDone, progOv, progErr, busy} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags got %b exp 0000", {progDone, progOv, progErr, busy}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spec_frame();
    clearObs();
    rxData  = specFrame[0];
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    checks++; if (progRecv !== 1'b1) begin errors++; $display("[TB] FAIL spec_recv_rise got %0b exp 1", progRecv); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL spec_busy got %0b exp 1", busy); end
    @(negedge clk);
    checks++; if (progRecv !== 1'b0) begin errors++; $display("[TB] FAIL spec_recv_fall got %0b exp 0", progRecv); end
    for (int i = 1; i < 12; i++) sendByte(specFrame[i], 0);
    repeat (3) @(negedge clk);
    checks++; if (obsAddr.size() !== 2) begin errors++; $display("[TB] FAIL spec_nwrites got %0d exp 2", obsAddr.size()); end
    if (obsAddr.size() == 2) begin
      checks++; if (obsAddr[0] !== int'(BASE_ADDR) || obsData[0] !== 32'h13) begin errors++; $display("[TB] FAIL spec_word0 got %0h@%0h exp 13@%0h", obsData[0], obsAddr[0], BASE_ADDR); end
      checks++; if (obsAddr[1] !== int'(BASE_ADDR) + 1 || obsData[1] !== 32'h6F) begin errors++; $display("[TB] FAIL spec_word1 got %0h@%0h exp 6f@%0h", obsData[1], obsAddr[1], int'(BASE_ADDR) + 1); end
    end
    checks++; if (obsRecv !== (CKSUM_ON ? 12 : 11)) begin errors++; $display("[TB] FAIL spec_pulses got %0d exp %0d", obsRecv, CKSUM_ON ? 12 : 11); end
    checks++; if ({progDone, progOv, progErr, busy} !== 4'b1000) begin errors++; $display("[TB] FAIL spec_flags got %b exp 1000", {progDone, progOv, progErr, busy}); end
    pulseRestart();
  endtask

  task automatic test_bad_cksum();
    clearObs();
    for (int i = 0; i < 11; i++) sendByte(specFrame[i], 0);
    sendByte(8'h7D, 0);
    repeat (3) @(negedge clk);
    checks++; if (obsAddr.size() !== 2) begin errors++; $display("[TB] FAIL badck_nwrites got %0d exp 2", obsAddr.size()); end
    checks++; if ({progDone, progErr} !== (CKSUM_ON ? 2'b01 : 2'b10)) begin errors++; $display("[TB] FAIL badck_flags got %b exp %b", {progDone, progErr}, CKSUM_ON ? 2'b01 : 2'b10); end
    pulseRestart();
    checks++; if ({progDone, progOv, progErr, busy} !== 4'b0000) begin errors++; $display("[TB] FAIL badck_restart got %b exp 0000", {progDone, progOv, progErr, busy}); end
    clearObs();
    sendByte(8'h13, 2);
    checks++; if (obsRecv !== 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL badck_idle pulses %0d busy %0b exp 0 0", obsRecv, busy); end
  endtask

  task automatic test_overflow();
    for (int n = CAP + 1; n <= 17; n += 17 - CAP - 1) begin
      clearObs();
      sendByte(SYNC, 0);
      sendByte(8'(n), 0);
      sendByte(8'h00, 0);
      for (int i = 0; i < 6; i++) sendByte(8'($urandom_range(0, 255)), 0);
      repeat (2) @(negedge clk);
      checks++; if ({progDone, progOv, progErr, busy} !== 4'b0100) begin errors++; $display("[TB] FAIL ov_flags n=%0d got %b exp 0100", n, {progDone, progOv, progErr, busy}); end
      checks++; if (obsAddr.size() !== 0 || obsRecv !== 3) begin errors++; $display("[TB] FAIL ov_activity n=%0d writes %0d pulses %0d exp 0 3", n, obsAddr.size(), obsRecv); end
      pulseRestart();
    end
  endtask

  task automatic test_timeout();
    int k;
    bit midOk;
    clearObs();
    sendByte(SYNC, 0);
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    sendByte(8'h11, 0);
    sendByte(8'h22, 0);
    midOk = 1'b0;
    for (k = 1; k <= 3 * TIMEOUT_CYC; k++) begin
      @(negedge clk);
      if (k == TIMEOUT_CYC - 1) midOk = (progErr === 1'b0) && (busy === 1'b1);
      if (progErr === 1'b1) break;
    end
    checks++; if (!midOk) begin errors++; $display("[TB] FAIL tmo_early err/busy wrong one cycle before expiry"); end
    checks++; if (k !== TIMEOUT_CYC) begin errors++; $display("[TB] FAIL tmo_latency got %0d exp %0d", k, TIMEOUT_CYC); end
    checks++; if (obsAddr.size() !== 0 || busy !== 1'b0 || progDone !== 1'b0) begin errors++; $display("[TB] FAIL tmo_state writes %0d busy %0b done %0b exp 0 0 0", obsAddr.size(), busy, progDone); end
    pulseRestart();
  endtask

  task automatic test_restart();
    clearObs();
    sendByte(SYNC, 0);
    sendByte(8'h02, 0);
    sendByte(8'h00, 1);
    pulseRestart();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_abort busy got %0b exp 0", busy); end
    restart = 1'b1;
    rxData  = SYNC;
    rxValid = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    rxValid = 1'b0;
    checks++; if (progRecv !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_wins recv %0b busy %0b exp 0 0", progRecv, busy); end
  endtask

  task automatic test_reset_midframe();
    clearObs();
    sendByte(SYNC, 0);
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    sendByte(8'hCC, 0);
    rst = 1'b1;
    #1;
    checks++; if ({memWe, busy, progRecv} !== 3'b000 || memAddr !== BASE_ADDR) begin errors++; $display("[TB] FAIL rstmid_outputs we/busy/recv %b addr %0h exp 000 %0h", {memWe, busy, progRecv}, memAddr, BASE_ADDR); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    buildFrame(1, 1'b0, 0, 0);
    runModel();
    clearObs();
    sendFrame(1);
    repeat (3) @(negedge clk);
    checks++; if (obsAddr.size() !== 1 || obsAddr[0] !== expAddr[0] || obsData[0] !== expData[0]) begin errors++; $display("[TB] FAIL rstmid_reload writes %0d first %0h exp 1 %0h@%0h", obsAddr.size(), (obsData.size() > 0) ? obsData[0] : '0, expData[0], expAddr[0]); end
    checks++; if (progDone !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_done got %0b exp 1", progDone); end
    pulseRestart();
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 24; it++) begin
      n = (it == 0) ? CAP : $urandom_range(0, CAP + 1);
      buildFrame(n, $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 2));
      runModel();
      clearObs();
      sendFrame((it % 3 == 0) ? 0 : 3);
      repeat (3) @(negedge clk);
      checks++; if (obsAddr.size() !== expAddr.size()) begin errors++; $display("[TB] FAIL rand%0d_nwrites got %0d exp %0d", it, obsAddr.size(), expAddr.size()); end
      for (int j = 0; j < expAddr.size() && j < obsAddr.size(); j++) begin
        checks++; if (obsAddr[j] !== expAddr[j] || obsData[j] !== expData[j]) begin errors++; $display("[TB] FAIL rand%0d_word%0d got %0h@%0h exp %0h@%0h", it, j, obsData[j], obsAddr[j], expData[j], expAddr[j]); end
      end
      checks++; if (obsRecv !== expRecv) begin errors++; $display("[TB] FAIL rand%0d_pulses got %0d exp %0d", it, obsRecv, expRecv); end
      checks++;
      if ({progDone, progOv, progErr, busy} !== {expStatus == ST_DONE, expStatus == ST_OV, expStatus == ST_ERR, 1'b0}) begin
        errors++;
        $display("[TB] FAIL rand%0d_flags got %b exp status %s", it, {progDone, progOv, progErr, busy}, expStatus.name());
      end
      pulseRestart();
    end
  endtask

  initial begin
    clk     = 1'b0;
    rst     = 1'b1;
    rxData  = '0;
    rxValid = 1'b0;
    restart = 1'b0;
    obsRecv = 0;
    test_reset();
    test_spec_frame();
    test_bad_cksum();
    test_overflow();
    test_timeout();
    test_restart();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
